// File: rtl/conv_layer_engine_if.sv
// conv_layer_engine_if: start/done handshake, feature-map and weight read port, output write port
interface conv_layer_engine_if #(parameter int DATA_SIZE = 64);
  logic compute_start, compute_done, rd_valid, out_we;
  logic [2:0][15:0] rd_index, out_index;
  logic [3:0][15:0] w_index;
  logic [DATA_SIZE-1:0] in_data, w_data, out_data;
  modport master(
    output compute_start, in_data, w_data,
    input compute_done, rd_index, w_index, rd_valid, out_we, out_index, out_data
  );
  modport slave(
    input compute_start, in_data, w_data,
    output compute_done, rd_index, w_index, rd_valid, out_we, out_index, out_data
  );
endinterface

// File: rtl/conv_layer_engine.sv
// conv_layer_engine: one-MAC-per-cycle convolution layer with ReLU, outputs written in raster order
module conv_layer_engine #(
  parameter int DATA_SIZE = 64,
  parameter int NUM_INPUT = 16,
  parameter int INPUT_DIM = 13,
  parameter int NUM_OUTPUT = 32,
  parameter int KERNEL_DIM = 3
) (
  input logic clk,
  input logic reset,
  conv_layer_engine_if.slave bus
);
  localparam int OUTPUT_DIM = INPUT_DIM - KERNEL_DIM + 1;
  localparam logic [15:0] K_LAST = 16'(KERNEL_DIM - 1);
  localparam logic [15:0] I_LAST = 16'(NUM_INPUT - 1);
  localparam logic [15:0] O_LAST = 16'(OUTPUT_DIM - 1);
  localparam logic [15:0] C_LAST = 16'(NUM_OUTPUT - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, WRITE, DONE} state_t;
  state_t s, s_n;
  logic [15:0] ic, kr, kc, oc, orow, ocol;
  logic [15:0] ic_n, kr_n, kc_n, oc_n, orow_n, ocol_n;
  logic [DATA_SIZE-1:0] acc, acc_n, prod;
  logic mac_d, last_k, last_o;
  assign prod = bus.in_data * bus.w_data;
  assign last_k = ic == I_LAST && kr == K_LAST && kc == K_LAST;
  assign last_o = oc == C_LAST && orow == O_LAST && ocol == O_LAST;
  // operands return one cycle after the read, so accumulation trails rd_valid by one cycle
  always_comb begin
    s_n = s;
    ic_n = ic;
    kr_n = kr;
    kc_n = kc;
    oc_n = oc;
    orow_n = orow;
    ocol_n = ocol;
    acc_n = s == CLEAR ? '0 : mac_d ? acc + prod : acc;
    case (s)
      IDLE: if (bus.compute_start) begin
        s_n = CLEAR;
        oc_n = '0;
        orow_n = '0;
        ocol_n = '0;
      end
      CLEAR: begin
        s_n = MAC;
        ic_n = '0;
        kr_n = '0;
        kc_n = '0;
      end
      MAC: begin
        s_n = last_k ? DRAIN : MAC;
        kc_n = kc == K_LAST ? '0 : kc + 16'd1;
        kr_n = kc != K_LAST ? kr : kr == K_LAST ? '0 : kr + 16'd1;
        ic_n = (kc != K_LAST || kr != K_LAST) ? ic : ic == I_LAST ? '0 : ic + 16'd1;
      end
      DRAIN: s_n = WRITE;
      WRITE: begin
        s_n = last_o ? DONE : CLEAR;
        ocol_n = ocol == O_LAST ? '0 : ocol + 16'd1;
        orow_n = ocol != O_LAST ? orow : orow == O_LAST ? '0 : orow + 16'd1;
        oc_n = (ocol != O_LAST || orow != O_LAST) ? oc : oc == C_LAST ? '0 : oc + 16'd1;
      end
      default: s_n = IDLE;
    endcase
  end
  // outputs are registered from next-state values so they line up with the state they belong to
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s <= IDLE;
      ic <= '0;
      kr <= '0;
      kc <= '0;
      oc <= '0;
      orow <= '0;
      ocol <= '0;
      acc <= '0;
      mac_d <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.out_we <= 1'b0;
      bus.compute_done <= 1'b0;
      bus.rd_index <= '0;
      bus.w_index <= '0;
      bus.out_index <= '0;
      bus.out_data <= '0;
    end else begin
      s <= s_n;
      ic <= ic_n;
      kr <= kr_n;
      kc <= kc_n;
      oc <= oc_n;
      orow <= orow_n;
      ocol <= ocol_n;
      acc <= acc_n;
      mac_d <= bus.rd_valid;
      bus.rd_valid <= s_n == MAC;
      bus.out_we <= s_n == WRITE;
      bus.compute_done <= s_n == DONE;
      if (s_n == MAC) begin
        bus.rd_index <= {ic_n, orow + kr_n, ocol + kc_n};
        bus.w_index <= {oc, ic_n, kr_n, kc_n};
      end
      if (s_n == WRITE) begin
        bus.out_index <= {oc, orow, ocol};
        bus.out_data <= acc_n[DATA_SIZE-1] ? '0 : acc_n;
      end
    end
endmodule

// File: tb/tb_conv_layer_engine.sv
// tb_conv_layer_engine: directed layers checked against a plain convolution reference model
module tb_conv_layer_engine;
  localparam int DS = 16, NI = 1, ID = 4, NO = 2, KD = 3, OD = ID - KD + 1;
  localparam int LAT = NO * OD * OD * (NI * KD * KD + 3);
  logic clk = 1'b0, reset = 1'b1;
  conv_layer_engine_if #(.DATA_SIZE(DS)) bus ();
  conv_layer_engine #(.DATA_SIZE(DS), .NUM_INPUT(NI), .INPUT_DIM(ID), .NUM_OUTPUT(NO),
                      .KERNEL_DIM(KD)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  logic signed [DS-1:0] img [ID][ID];
  logic signed [DS-1:0] wts [NO][KD][KD];
  logic [47:0] exp_idx [$];
  logic [DS-1:0] exp_dat [$];
  logic [DS-1:0] got [64];
  logic [47:0] got_idx [64];
  int writes = 0, dones = 0, chk = 0, err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DS-1:0] fetch_in(input logic [47:0] a);
    int ch, r, c;
    ch = int'(a[47:32]);
    r = int'(a[31:16]);
    c = int'(a[15:0]);
    return (ch < NI && r < ID && c < ID) ? img[r][c] : 16'h5a5a;
  endfunction

  function automatic logic [DS-1:0] fetch_w(input logic [63:0] a);
    int o, ch, r, c;
    o = int'(a[63:48]);
    ch = int'(a[47:32]);
    r = int'(a[31:16]);
    c = int'(a[15:0]);
    return (o < NO && ch < NI && r < KD && c < KD) ? wts[o][r][c] : 16'h5a5a;
  endfunction

  // reference: plain convolution of the first n outputs in raster order, truncated then ReLU
  task automatic model(input int n);
    int oc, r, c;
    longint s;
    for (int o = 0; o < n; o++) begin
      oc = o / (OD * OD);
      r = (o / OD) % OD;
      c = o % OD;
      s = 0;
      for (int i = 0; i < KD; i++)
        for (int j = 0; j < KD; j++)
          s += longint'(img[r+i][c+j]) * longint'(wts[oc][i][j]);
      exp_idx.push_back({16'(oc), 16'(r), 16'(c)});
      exp_dat.push_back(s[DS-1] ? '0 : s[DS-1:0]);
    end
  endtask

  task automatic fill(input logic [DS-1:0] iv, input logic [DS-1:0] wv);
    for (int r = 0; r < ID; r++) for (int c = 0; c < ID; c++) img[r][c] = iv;
    for (int o = 0; o < NO; o++) for (int r = 0; r < KD; r++) for (int c = 0; c < KD; c++) wts[o][r][c] = wv;
  endtask

  task automatic run_one(input string name);
    int n;
    @(negedge clk);
    bus.compute_start = 1'b1;
    @(negedge clk);
    bus.compute_start = 1'b0;
    n = 1;
    while (!bus.compute_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n - 1), 64'(LAT));
    repeat (4) @(negedge clk);
    #1;
  endtask

  // memory: data for a read issued in one cycle is presented during the next cycle
  initial begin
    logic pv;
    logic [47:0] pi;
    logic [63:0] pw;
    pv = 1'b0;
    pi = '0;
    pw = '0;
    bus.in_data = '0;
    bus.w_data = '0;
    forever begin
      @(negedge clk);
      bus.in_data = pv ? fetch_in(pi) : 16'h5a5a;
      bus.w_data = pv ? fetch_w(pw) : 16'h5a5a;
      pv = bus.rd_valid;
      pi = bus.rd_index;
      pw = bus.w_index;
    end
  end

  always @(negedge clk) if (!reset) begin
    if (bus.compute_done) dones++;
    if (bus.out_we) begin
      if (exp_idx.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_write: index %0h data %0h, none required", bus.out_index, bus.out_data);
      end else begin
        check("out_index", 64'(bus.out_index), 64'(exp_idx.pop_front()));
        check("out_data", 64'(bus.out_data), 64'(exp_dat.pop_front()));
      end
      got[writes % 64] = bus.out_data;
      got_idx[writes % 64] = bus.out_index;
      writes++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    bus.compute_start = 1'b0;
    fill(16'd1, 16'd1);
    repeat (2) @(negedge clk);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_out_we", 64'(bus.out_we), 64'd0);
    check("rst_done", 64'(bus.compute_done), 64'd0);
    check("rst_rd_index", 64'(bus.rd_index), 64'd0);
    check("rst_w_index", 64'(bus.w_index), 64'd0);
    check("rst_out", 64'({bus.out_index, bus.out_data}), 64'd0);
    reset = 1'b0;

    writes = 0; dones = 0; model(8);
    run_one("latency_ones");
    check("writes_ones", 64'(writes), 64'd8);
    check("dones_ones", 64'(dones), 64'd1);
    for (int k = 0; k < 8; k++) check("lit_ones", 64'(got[k]), 64'd9);
    check("lit_idx1", 64'(got_idx[1]), 64'h0000_0000_0001);
    check("lit_idx4", 64'(got_idx[4]), 64'h0001_0000_0000);
    check("lit_idx7", 64'(got_idx[7]), 64'h0001_0001_0001);

    fill(16'd1, 16'hffff);
    writes = 0; dones = 0; model(8);
    run_one("latency_neg");
    for (int k = 0; k < 8; k++) check("lit_relu", 64'(got[k]), 64'd0);

    fill(16'h4000, 16'd4);
    writes = 0; dones = 0; model(8);
    run_one("latency_trunc");
    for (int k = 0; k < 8; k++) check("lit_trunc", 64'(got[k]), 64'd0);

    fill(16'h2000, 16'd1);
    writes = 0; dones = 0; model(8);
    run_one("latency_wrap");
    check("lit_wrap", 64'(got[0]), 64'h2000);

    for (int r = 0; r < ID; r++) for (int c = 0; c < ID; c++) img[r][c] = 16'(r * 4 + c + 1);
    for (int r = 0; r < KD; r++) for (int c = 0; c < KD; c++) begin
      wts[0][r][c] = 16'(r * 3 + c + 1);
      wts[1][r][c] = 16'(r - c);
    end
    writes = 0; dones = 0; model(8);
    run_one("latency_pattern");
    check("lit_pat0", 64'(got[0]), 64'd348);
    check("lit_pat4", 64'(got[4]), 64'd18);
    check("writes_pattern", 64'(writes), 64'd8);

    // start held high: second layer only after DONE has returned to IDLE
    fill(16'd1, 16'd1);
    writes = 0; dones = 0; model(8); model(8);
    @(negedge clk);
    bus.compute_start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.compute_done && n < 400);
    check("held_first_done", 64'(n), 64'(LAT + 1));
    m = 0;
    do begin
      @(negedge clk);
      m++;
      if (m == 1) check("held_done_width", 64'(bus.compute_done), 64'd0);
    end while (!bus.compute_done && m < 400);
    check("held_second_done", 64'(m), 64'(LAT + 2));
    bus.compute_start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("held_writes", 64'(writes), 64'd16);
    check("held_dones", 64'(dones), 64'd2);

    // reset during MAC of output 3
    writes = 0; dones = 0; model(3);
    @(negedge clk);
    bus.compute_start = 1'b1;
    @(negedge clk);
    bus.compute_start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_in_mac", 64'(bus.rd_valid), 64'd1);
    check("abort_writes", 64'(writes), 64'd3);
    reset = 1'b1;
    #1;
    check("abort_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("abort_rd_index", 64'(bus.rd_index), 64'd0);
    check("abort_w_index", 64'(bus.w_index), 64'd0);
    check("abort_out", 64'({bus.out_we, bus.out_index, bus.out_data}), 64'd0);
    check("abort_done", 64'(bus.compute_done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("abort_no_resume_writes", 64'(writes), 64'd3);
    check("abort_no_resume_done", 64'(dones), 64'd0);
    writes = 0; dones = 0; model(8);
    run_one("latency_after_abort");
    check("after_abort_writes", 64'(writes), 64'd8);
    check("after_abort_dones", 64'(dones), 64'd1);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/conv_layer_engine.md
CONV_LAYER_ENGINE -- requirements
Module: conv_layer_engine

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_SIZE, 64, datapath width.
- NUM_INPUT, 16, input channels.
- INPUT_DIM, 13, input feature-map side.
- NUM_OUTPUT, 32, output channels.
- KERNEL_DIM, 3, kernel side.
- Derived: OUTPUT_DIM = INPUT_DIM-KERNEL_DIM+1.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- compute_start  in  1  start request from the layer scheduler.
- compute_done  out  1  one-cycle completion pulse.
- rd_index  out  16x3  input read {channel, row, col}.
- w_index  out  16x4  weight read {out_ch, in_ch, krow, kcol}.
- rd_valid  out  1  read indices valid this cycle.
- in_data  in  DATA_SIZE  input value, one cycle after rd_valid.
- w_data  in  DATA_SIZE  weight value, one cycle after rd_valid.
- out_we  out  1  output write strobe.
- out_index  out  16x3  output write {out_ch, row, col}.
- out_data  out  DATA_SIZE  output value.

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, MAC, DRAIN, WRITE and DONE.

REQ-004 In IDLE, compute_start sampled high SHALL cause entry to CLEAR at the next edge and reset the output counters {oc,orow,ocol} to 0; compute_start sampled high in any other state SHALL be ignored.

REQ-005 CLEAR SHALL last one cycle, zero the accumulator, zero the kernel counters {ic,kr,kc}, then go to MAC.

REQ-006 In MAC, rd_valid SHALL be 1 every cycle, and the indices SHALL be driven as follows:
- rd_index = {ic, orow+kr, ocol+kc}.
- w_index = {oc, ic, kr, kc}.

REQ-007 The kernel counters SHALL advance kc fastest, then kr, then ic, each wrapping to 0 at its limit (KERNEL_DIM, KERNEL_DIM, NUM_INPUT). After the read with ic=NUM_INPUT-1, kr=kc=KERNEL_DIM-1, the FSM SHALL go to DRAIN, so MAC lasts exactly NUM_INPUT*KERNEL_DIM^2 cycles.

REQ-008 One cycle after each rd_valid, the accumulator SHALL add the signed product in_data*w_data, truncated to DATA_SIZE bits, with two's-complement wrap and no saturation.

REQ-009 DRAIN SHALL last one cycle so that the final product is accumulated; rd_valid SHALL be 0.

REQ-010 WRITE SHALL last one cycle, with the following outputs:
- out_we=1.
- out_index={oc,orow,ocol}.
- out_data = accumulator if non-negative, else 0 (ReLU).

REQ-011 After WRITE, the output counters SHALL advance ocol fastest, then orow, then oc, each wrapping at OUTPUT_DIM, OUTPUT_DIM and NUM_OUTPUT respectively.
- If the just-written output was {NUM_OUTPUT-1, OUTPUT_DIM-1, OUTPUT_DIM-1}, the next state SHALL be DONE.
- Otherwise the next state SHALL be CLEAR.

REQ-012 DONE SHALL last one cycle with compute_done=1, then return to IDLE. compute_done SHALL be 1 in no other state.

REQ-013 Total latency SHALL be exactly NUM_OUTPUT*OUTPUT_DIM^2*(NUM_INPUT*KERNEL_DIM^2+3) cycles from the edge sampling compute_start to the edge entering DONE.

REQ-014 When not asserted, out_we and rd_valid SHALL be 0. Index and data outputs SHALL be registered and hold their last values when not strobed.

REQ-015 compute_start arriving in the same cycle that DONE is exited SHALL be ignored; a new start is accepted only while in IDLE.

Reset
REQ-016 Asserting reset SHALL asynchronously force the following, at any time including mid-computation:
- State IDLE.
- All counters and the accumulator to 0.
- compute_done=0, rd_valid=0, out_we=0.
- All index and data outputs to 0.

REQ-017 After reset deasserts, the block SHALL need a fresh compute_start and SHALL NOT resume the interrupted layer.

Verification
REQ-018 The bench SHALL cover the following directed scenarios. Parameters for all scenarios: NUM_INPUT=1, INPUT_DIM=4, KERNEL_DIM=3, NUM_OUTPUT=2, DATA_SIZE=16.
- Single-cycle compute_start, in_data=1, w_data=1 -> 8 out_we pulses.
- Same stimulus, data and latency checks:
  - every out_data=9;
  - out_index sequence is {0,0,0},{0,0,1},{0,1,0},{0,1,1},{1,0,0}...{1,1,1};
  - compute_done is high for exactly one cycle, 96 cycles after the start edge.
- in_data=1, w_data=-1 -> every out_data=0 (ReLU).
- in_data=0x4000, w_data=4 -> product truncates, accumulator wraps, out_data=0.
- compute_start held high throughout -> no restart mid-layer; a second layer begins only from IDLE after the compute_done pulse.
- reset asserted during MAC of output 3 -> outputs are zero immediately; no out_we or compute_done appear afterwards until a new compute_start, which yields a full 96-cycle run.
